// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, wrap or saturate mode, terminal-count and wrap flags.
// Optional registered Gray-coded output built only when GRAY_OUT_EN is defined; otherwise q_gray is 0.
module mod_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] q_gray
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
        end
    endgenerate

    // Terminal value held in WIDTH bits so MODULUS=2**WIDTH rolls over cleanly.
    localparam logic [WIDTH-1:0] TERM      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam bit               WRAP_MODE = (SATURATE == 0);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (q_reg == TERM);
    assign at_bottom = (q_reg == '0);

    // Load beats count; out-of-range loads clamp to the terminal value.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_val > TERM) ? TERM : load_val;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    q_next    = WRAP_MODE ? '0 : TERM;
                    wrap_next = WRAP_MODE;
                end else begin
                    q_next = q_reg + ONE;
                end
            end else begin
                if (at_bottom) begin
                    q_next    = WRAP_MODE ? TERM : '0;
                    wrap_next = WRAP_MODE;
                end else begin
                    q_next = q_reg - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    assign q    = q_reg;
    assign wrap = wrap_reg;
    assign tc   = up ? at_top : at_bottom;

`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_reg;

    // Encoded from q_next so the Gray value lands on the same edge as q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_reg <= '0;
        end else begin
            gray_reg <= q_next ^ (q_next >> 1);
        end
    end

    assign q_gray = gray_reg;
`else
    assign q_gray = '0;
`endif

endmodule
